// File: rtl/f_minmax_reduce.sv
// Streaming IEEE-754 single-precision max/min reduction over a counted burst.
// Reports the winning value, its zero-based index, and whether any NaN was seen.
module f_minmax_reduce #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_nan,
  output logic             busy
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state_q;
  logic             modeMin_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] beat_q;
  logic [31:0]      accData_q;
  logic [CNT_W-1:0] accIdx_q;
  logic             accFull_q;
  logic             nanSeen_q;

  logic             inReady_q;
  logic             outValid_q;
  logic [31:0]      outData_q;
  logic [CNT_W-1:0] outIdx_q;
  logic             outNan_q;
  logic             busy_q;

  logic [31:0]      accData_d;
  logic [CNT_W-1:0] accIdx_d;
  logic             accFull_d;
  logic             nanSeen_d;

  logic             beatFire;
  logic             lastBeat;
  logic             inIsNan;
  logic [31:0]      keyIn;
  logic [31:0]      keyAcc;
  logic             inBetter;
  logic             takeIn;

  // Maps a float onto an unsigned key whose ordering matches the total order
  // (negatives inverted, positives offset above them, so -0.0 sits just below +0.0).
  function automatic logic [31:0] orderKey(input logic [31:0] f);
    return f[31] ? ~f : {1'b1, f[30:0]};
  endfunction

  assign beatFire = in_valid && inReady_q;
  assign lastBeat = (beat_q == (count_q - CNT_W'(1)));
  assign inIsNan  = (&in_data[30:23]) && (|in_data[22:0]);
  assign keyIn    = orderKey(in_data);
  assign keyAcc   = orderKey(accData_q);
  assign inBetter = modeMin_q ? (keyIn < keyAcc) : (keyIn > keyAcc);
  assign takeIn   = beatFire && !inIsNan && (!accFull_q || inBetter);

  always_comb begin
    accData_d = accData_q;
    accIdx_d  = accIdx_q;
    accFull_d = accFull_q;
    nanSeen_d = nanSeen_q | (beatFire && inIsNan);
    if (takeIn) begin
      accData_d = in_data;
      accIdx_d  = beat_q;
      accFull_d = 1'b1;
    end
  end

  // The final beat folds straight into the result registers so out_valid
  // rises on the cycle right after that beat transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      modeMin_q  <= 1'b0;
      count_q    <= '0;
      beat_q     <= '0;
      accData_q  <= '0;
      accIdx_q   <= '0;
      accFull_q  <= 1'b0;
      nanSeen_q  <= 1'b0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outIdx_q   <= '0;
      outNan_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            modeMin_q <= mode;
            count_q   <= count;
            beat_q    <= '0;
            accFull_q <= 1'b0;
            nanSeen_q <= 1'b0;
            busy_q    <= 1'b1;
            if (count != '0) begin
              state_q   <= ACCUM;
              inReady_q <= 1'b1;
            end else begin
              state_q    <= HOLD;
              outValid_q <= 1'b1;
              outData_q  <= QNAN;
              outIdx_q   <= '0;
              outNan_q   <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (beatFire) begin
            beat_q    <= beat_q + CNT_W'(1);
            accData_q <= accData_d;
            accIdx_q  <= accIdx_d;
            accFull_q <= accFull_d;
            nanSeen_q <= nanSeen_d;
            if (lastBeat) begin
              state_q    <= HOLD;
              inReady_q  <= 1'b0;
              outValid_q <= 1'b1;
              outData_q  <= accFull_d ? accData_d : QNAN;
              outIdx_q   <= accFull_d ? accIdx_d : '0;
              outNan_q   <= nanSeen_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b0;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_idx   = outIdx_q;
  assign out_nan   = outNan_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_f_minmax_reduce.sv
// Directed bench for f_minmax_reduce; inputs are driven and outputs sampled on
// the falling clock edge so every observation sits half a cycle from the active edge.
module tb_f_minmax_reduce;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_idx;
  logic             out_nan;
  logic             busy;

  int errCount   = 0;
  int checkCount = 0;

  f_minmax_reduce #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .count    (count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_nan  (out_nan),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle, then scrambles mode/count so later changes must be ignored.
  task automatic applyStimulus(input logic m, input logic [CNT_W-1:0] c);
    start = 1'b1;
    mode  = m;
    count = c;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    count = c + CNT_W'(3);
  endtask

  // Holds one beat until it is accepted, bounded so a missing in_ready cannot hang.
  task automatic sendBeat(input logic [31:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [31:0] expData,
                             input logic [CNT_W-1:0] expIdx, input logic expNan);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, out_data, expData);
    checkOutput({tag, "_idx"}, 32'(out_idx), 32'(expIdx));
    checkOutput({tag, "_nan"}, 32'(out_nan), 32'(expNan));
  endtask

  task automatic drainResult(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_drain_busy"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] toggleData  [5] = '{32'h4000_0000, 32'hC2C8_0000, 32'h3F80_0000, 32'hC348_0000, 32'h4040_0000};
  logic        toggleValid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    count     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
    checkOutput("rst_out_nan", 32'(out_nan), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Max with a tie on 3.5: earlier index wins.
    applyStimulus(1'b0, 8'd4);
    checkOutput("max_in_ready", 32'(in_ready), 32'd1);
    checkOutput("max_busy", 32'(busy), 32'd1);
    sendBeat(32'h3F80_0000);
    sendBeat(32'hC000_0000);
    sendBeat(32'h4060_0000);
    sendBeat(32'h4060_0000);
    checkResult("max_tie", 32'h4060_0000, 8'd2, 1'b0);
    checkOutput("max_hold_in_ready", 32'(in_ready), 32'd0);
    drainResult("max_tie");
    checkOutput("max_idle_data_kept", out_data, 32'h4060_0000);

    // Min where -0.0 must beat +0.0 and a NaN only raises the flag.
    applyStimulus(1'b1, 8'd3);
    sendBeat(32'h0000_0000);
    sendBeat(32'h8000_0000);
    sendBeat(32'h7FC0_0001);
    checkResult("min_zero", 32'h8000_0000, 8'd1, 1'b1);
    drainResult("min_zero");

    // All elements NaN.
    applyStimulus(1'b0, 8'd2);
    sendBeat(32'h7FC0_0000);
    sendBeat(32'h7FC0_0000);
    checkResult("all_nan", 32'h7FC0_0000, 8'd0, 1'b1);
    drainResult("all_nan");

    // Empty reduction: result held while out_ready is low, start pulses ignored.
    applyStimulus(1'b0, 8'd0);
    checkResult("cnt0", 32'h7FC0_0000, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      @(negedge clk);
      checkOutput("cnt0_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("cnt0_hold_data", out_data, 32'h7FC0_0000);
      checkOutput("cnt0_hold_in_ready", 32'(in_ready), 32'd0);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    checkOutput("cnt0_exit_busy", 32'(busy), 32'd0);
    checkOutput("cnt0_exit_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("cnt0_start_ignored", 32'(busy), 32'd0);

    // Min with in_valid toggling: idle cycles carry smaller values that must not count.
    applyStimulus(1'b1, 8'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = toggleValid[i];
      in_data  = toggleData[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkResult("toggle_min", 32'h3F80_0000, 8'd1, 1'b0);
    drainResult("toggle_min");

    // Abort after two handshaked beats with an asynchronous reset mid-cycle.
    applyStimulus(1'b1, 8'd3);
    for (int i = 0; i < 3; i++) begin
      in_valid = toggleValid[i];
      in_data  = toggleData[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("abort_still_busy", 32'(busy), 32'd1);
    checkOutput("abort_no_result", 32'(out_valid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_stays_idle", 32'(out_valid), 32'd0);

    // Clean run after abort: max of two negatives picks -0.0.
    applyStimulus(1'b0, 8'd2);
    sendBeat(32'hBF80_0000);
    sendBeat(32'h8000_0000);
    checkResult("post_abort", 32'h8000_0000, 8'd1, 1'b0);
    drainResult("post_abort");

    // Full-width count: +inf at 200 and again at 254, earlier one wins.
    applyStimulus(1'b0, 8'd255);
    for (int i = 0; i < 255; i++) begin
      sendBeat((i == 200 || i == 254) ? 32'h7F80_0000 : 32'h3F80_0000);
    end
    checkResult("cnt_max", 32'h7F80_0000, 8'd200, 1'b0);
    drainResult("cnt_max");

    // Min with -inf at the final position.
    applyStimulus(1'b1, 8'd3);
    sendBeat(32'hFF7F_FFFF);
    sendBeat(32'h0000_0001);
    sendBeat(32'hFF80_0000);
    checkResult("neg_inf", 32'hFF80_0000, 8'd2, 1'b0);
    drainResult("neg_inf");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
